// File: rtl/bus_arb_pkg.sv
// Shared definitions for bus-hold arbiters: FSM state encoding and default sizing.
package bus_arb_pkg;

  localparam int DEF_N      = 4;
  localparam int DEF_MAXCYC = 64;
  localparam int DEF_GAP    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLDREQ,
    ST_GRANT,
    ST_RELEASE,
    ST_GAP
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int W = $clog2(N);

  int           pos;
  logic [W-1:0] pidx;

  // Scan from the farthest offset down to the pointer so the nearest set bit wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    pidx    = '0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = int'(ptr_i) + off;
      if (pos >= N) pos = pos - N;
      pidx = W'(pos);
      if (req_i[pidx]) begin
        valid_o = 1'b1;
        idx_o   = pidx;
      end
    end
  end

endmodule

// File: rtl/dma_hold_arbiter.sv
// Round-robin HOLD/HLDA arbiter for the 8088 local bus: raises HOLD for the
// winning requester, grants it once HLDA arrives, bounds the tenure and
// guarantees the CPU an idle gap between tenures.
module dma_hold_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int MAXCYC = DEF_MAXCYC,
  parameter int GAP    = DEF_GAP
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N-1:0]         REQ,
  input  logic [N-1:0]         DONE,
  input  logic                 HLDA,
  output logic                 HOLD,
  output logic [N-1:0]         GNT,
  output logic [$clog2(N)-1:0] GNTID,
  output logic                 BUSY,
  output logic                 TMO
);

  localparam int W  = $clog2(N);
  localparam int CW = $clog2(MAXCYC);
  localparam int GW = $clog2(GAP + 1);

  arb_state_e    state_q, state_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [W-1:0]  gntid_q, gntid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          tmo_q, tmo_d;
  logic [N-1:0]  gnt_q, gnt_d;

  logic          pick_valid;
  logic [W-1:0]  pick_idx;
  logic          early_end;
  logic          timeout;
  logic [W-1:0]  ptr_after;

  rr_pick #(.N(N)) u_pick (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // A tenure ends early on DONE, withdrawal, or the CPU dropping HLDA.
  assign early_end = DONE[gntid_q] || !REQ[gntid_q] || !HLDA;
  assign timeout   = (cnt_q == CW'(MAXCYC - 1));
  assign ptr_after = (gntid_q == W'(N - 1)) ? '0 : gntid_q + W'(1);

  // State, counters and all output registers; reset is synchronous.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gntid_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gntid_q <= gntid_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic: arbitration, handshake progress, tenure and gap counting.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gntid_d = gntid_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gntid_d = pick_idx;
          state_d = ST_HOLDREQ;
        end
      end
      ST_HOLDREQ: begin
        if (HLDA) begin
          if (REQ[gntid_q]) begin
            state_d = ST_GRANT;
            cnt_d   = '0;
          end else begin
            state_d = ST_RELEASE;
            ptr_d   = ptr_after;
          end
        end
      end
      ST_GRANT: begin
        if (early_end || timeout) begin
          state_d = ST_RELEASE;
          ptr_d   = ptr_after;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (!HLDA) begin
          state_d = ST_GAP;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = ST_IDLE;
        else                       gap_d   = gap_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    hold_d = (state_d == ST_HOLDREQ) || (state_d == ST_GRANT);
    busy_d = hold_d || (state_d == ST_RELEASE);
    gnt_d  = '0;
    if (state_d == ST_GRANT) gnt_d[gntid_d] = 1'b1;
    tmo_d  = (state_q == ST_GRANT) && timeout && !early_end;
  end

  assign HOLD  = hold_q;
  assign GNT   = gnt_q;
  assign GNTID = gntid_q;
  assign BUSY  = busy_q;
  assign TMO   = tmo_q;

endmodule
